// File: rtl/ntt_ctrl.sv
// NTT/INTT layer sequencer: issues butterfly reads and twiddle indices, and
// replays them as write-backs LAT cycles later. Optional cycle counter: NTT_CTRL_PERF_CNT_EN.
module ntt_ctrl #(
    parameter int unsigned LAT = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        rd_en_o,
    output logic [7:0]  rd_addr_a_o,
    output logic [7:0]  rd_addr_b_o,
    output logic [6:0]  zeta_idx_o,
    output logic [1:0]  bf_mode_o,
    output logic        wr_en_o,
    output logic [7:0]  wr_addr_a_o,
    output logic [7:0]  wr_addr_b_o
`ifdef NTT_CTRL_PERF_CNT_EN
    ,
    output logic [11:0] cycle_cnt_o
`endif
);

    localparam int unsigned DrainW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [2:0]          layer_q, layer_d;
    logic [6:0]          bf_cnt_q, bf_cnt_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [6:0]          zeta_q, zeta_d;

    logic [LAT-1:0]      pipe_vld_q;
    logic [7:0]          pipe_a_q [LAT];
    logic [7:0]          pipe_b_q [LAT];

    logic                accept;
    logic [7:0]          addr_inc;
    logic [6:0]          zeta_step;

    assign accept    = (state_q == StIdle) && start_i && !mode_i[1];
    assign addr_inc  = addr_q + 8'd1;
    assign zeta_step = mode_q[0] ? (zeta_q - 7'd1) : (zeta_q + 7'd1);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        layer_d  = layer_q;
        bf_cnt_d = bf_cnt_q;
        drain_d  = drain_q;
        addr_d   = addr_q;
        len_d    = len_q;
        zeta_d   = zeta_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StIssue;
                    mode_d   = mode_i;
                    layer_d  = 3'd0;
                    bf_cnt_d = 7'd0;
                    addr_d   = 8'd0;
                    len_d    = mode_i[0] ? 8'd2 : 8'd128;
                    zeta_d   = mode_i[0] ? 7'd127 : 7'd1;
                end
            end
            StIssue: begin
                if (bf_cnt_q == 7'd127) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    bf_cnt_d = bf_cnt_q + 7'd1;
                    // Crossing into the next group skips the upper half already covered by j+len.
                    if ((addr_inc & (len_q - 8'd1)) == 8'd0) begin
                        addr_d = addr_inc + len_q;
                        zeta_d = zeta_step;
                    end else begin
                        addr_d = addr_inc;
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainW'(LAT - 1)) begin
                    if (layer_q == 3'd6) begin
                        state_d = StFinish;
                    end else begin
                        state_d  = StIssue;
                        layer_d  = layer_q + 3'd1;
                        bf_cnt_d = 7'd0;
                        addr_d   = 8'd0;
                        len_d    = mode_q[0] ? (len_q << 1) : (len_q >> 1);
                        zeta_d   = zeta_step;
                    end
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            mode_q   <= 2'd0;
            layer_q  <= 3'd0;
            bf_cnt_q <= 7'd0;
            drain_q  <= '0;
            addr_q   <= 8'd0;
            len_q    <= 8'd0;
            zeta_q   <= 7'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            layer_q  <= layer_d;
            bf_cnt_q <= bf_cnt_d;
            drain_q  <= drain_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            zeta_q   <= zeta_d;
        end
    end

    // Write-back delay line; reset drops in-flight reads so an abort never writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_a_q[i] <= 8'd0;
                pipe_b_q[i] <= 8'd0;
            end
        end else begin
            pipe_vld_q[0] <= rd_en_o;
            pipe_a_q[0]   <= rd_addr_a_o;
            pipe_b_q[0]   <= rd_addr_b_o;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_a_q[i]   <= pipe_a_q[i-1];
                pipe_b_q[i]   <= pipe_b_q[i-1];
            end
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StFinish);
    assign rd_en_o     = (state_q == StIssue);
    assign rd_addr_a_o = addr_q;
    assign rd_addr_b_o = addr_q + len_q;
    assign zeta_idx_o  = zeta_q;
    assign bf_mode_o   = mode_q;
    assign wr_en_o     = pipe_vld_q[LAT-1];
    assign wr_addr_a_o = pipe_a_q[LAT-1];
    assign wr_addr_b_o = pipe_b_q[LAT-1];

`ifdef NTT_CTRL_PERF_CNT_EN
    logic [11:0] cycle_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_q <= 12'd0;
        end else if (accept) begin
            cycle_cnt_q <= 12'd0;
        end else if (busy_o) begin
            cycle_cnt_q <= cycle_cnt_q + 12'd1;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
`endif

endmodule
